// File: rtl/cfg_record_unpacker_if.sv
// Byte-stream in / decoded-record out bundle for cfg_record_unpacker.
// slave is the unpacker side, master is the stream source / record sink.
interface cfg_record_unpacker_if #(
    parameter int PAYLOAD_BYTES = 4
);
    logic                       in_valid;
    logic [7:0]                 in_data;
    logic                       in_last;
    logic                       in_ready;
    logic                       out_valid;
    logic                       out_ready;
    logic [2:0]                 out_mode;
    logic [1:0]                 out_kind;
    logic [8*PAYLOAD_BYTES-1:0] out_data;
    logic                       err_valid;
    logic [1:0]                 err_code;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_mode, out_kind, out_data, err_valid, err_code
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_mode, out_kind, out_data, err_valid, err_code
    );
endinterface

// File: rtl/cfg_record_unpacker.sv
// Unpacks header/payload/checksum byte frames into records, with one error
// pulse per bad frame (framing > checksum > illegal kind).
//
// state   | meaning
// IDLE    | waiting for header byte
// PAYLOAD | collecting PAYLOAD_BYTES payload bytes
// CHECK   | waiting for checksum byte (must carry in_last)
// OUT     | record presented, waiting for out_ready
// DRAIN   | discarding bytes through the next in_last
module cfg_record_unpacker #(
    parameter int PAYLOAD_BYTES = 4
) (
    input logic                  clk,
    input logic                  rst,
    cfg_record_unpacker_if.slave bus
);
    localparam int CW = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PAYLOAD_BYTES - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PAYLOAD = 3'd1;
    localparam logic [2:0] CHECK   = 3'd2;
    localparam logic [2:0] OUT     = 3'd3;
    localparam logic [2:0] DRAIN   = 3'd4;

    localparam logic [1:0] ERR_CSUM  = 2'd1;
    localparam logic [1:0] ERR_FRAME = 2'd2;
    localparam logic [1:0] ERR_KIND  = 2'd3;

    logic [2:0]                 state;
    logic [CW-1:0]              cnt;
    logic [7:0]                 csum;
    logic [2:0]                 mode;
    logic [2:0]                 kind;
    logic [8*PAYLOAD_BYTES-1:0] data;
    logic                       out_valid;
    logic                       err_valid;
    logic [1:0]                 err_code;
    logic                       fire;

    // in_ready is forced low while rst is held, not just after the reset edge.
    assign bus.in_ready  = !rst && (state != OUT);
    assign fire          = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid;
    assign bus.out_mode  = mode;
    assign bus.out_kind  = kind[1:0];
    assign bus.out_data  = data;
    assign bus.err_valid = err_valid;
    assign bus.err_code  = err_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            csum      <= '0;
            mode      <= '0;
            kind      <= '0;
            data      <= '0;
            out_valid <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= '0;
        end else begin
            err_valid <= 1'b0;
            err_code  <= '0;
            case (state)
                IDLE: if (fire) begin
                    mode <= bus.in_data[7:5];
                    kind <= bus.in_data[4:2];
                    csum <= bus.in_data;
                    cnt  <= '0;
                    if (bus.in_last) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_FRAME;
                    end else begin
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: if (fire) begin
                    data[8*cnt +: 8] <= bus.in_data;
                    csum             <= csum ^ bus.in_data;
                    cnt              <= cnt + 1'b1;
                    if (bus.in_last) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_FRAME;
                        state     <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= CHECK;
                    end
                end
                CHECK: if (fire) begin
                    if (!bus.in_last) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_FRAME;
                        state     <= DRAIN;
                    end else if (csum != bus.in_data) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_CSUM;
                        state     <= IDLE;
                    end else if (kind > 3'd3) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_KIND;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: if (bus.out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                DRAIN: if (fire && bus.in_last) begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cfg_record_unpacker.sv
// Scoreboard bench for cfg_record_unpacker with PAYLOAD_BYTES=4.
module tb_cfg_record_unpacker;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        bit         is_err;
        logic [1:0] code;
        logic [2:0] mode;
        logic [1:0] kind;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    cfg_record_unpacker_if #(.PAYLOAD_BYTES(4)) bus ();
    cfg_record_unpacker #(.PAYLOAD_BYTES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t e;
        e.is_err = 1'b1; e.code = code; e.mode = '0; e.kind = '0; e.data = '0;
        sbq.push_back(e);
    endtask

    // Reference decode of a correctly framed 6-byte frame.
    task automatic push_model(input logic [7:0] h, p0, p1, p2, p3, cs);
        exp_t e;
        logic [7:0] x;
        x = h ^ p0 ^ p1 ^ p2 ^ p3;
        if (x != cs) push_err(2'd1);
        else if (h[4:2] > 3'd3) push_err(2'd3);
        else begin
            e.is_err = 1'b0; e.code = '0; e.mode = h[7:5]; e.kind = h[3:2];
            e.data = {p3, p2, p1, p0};
            sbq.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Called just after a posedge; returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] b, input logic last);
        int n = 0;
        bus.in_valid = 1'b1; bus.in_data = b; bus.in_last = last;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 0, 1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.in_last  = 1'b1;
    endtask

    task automatic frame(input logic [7:0] h, p0, p1, p2, p3, cs);
        push_model(h, p0, p1, p2, p3, cs);
        send(h, 1'b0); send(p0, 1'b0); send(p1, 1'b0);
        send(p2, 1'b0); send(p3, 1'b0); send(cs, 1'b1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sbq.size() == 0) chk("unexpected_record", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("rec_is_err", 0, e.is_err);
                chk("rec_mode", bus.out_mode, e.mode);
                chk("rec_kind", bus.out_kind, e.kind);
                chk("rec_data", bus.out_data, e.data);
            end
        end
        if (bus.err_valid === 1'b1) begin
            if (sbq.size() == 0) chk("unexpected_err", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("err_is_err", 1, e.is_err);
                chk("err_code", bus.err_code, e.code);
            end
        end else if (mon_en) begin
            chk("err_code_idle", bus.err_code, 0);
        end
    end

    initial begin
        logic [7:0] h, p0, p1, p2, p3, cs;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_err_valid", bus.err_valid, 0);
        chk("rst_err_code", bus.err_code, 0);
        chk("rst_out_mode", bus.out_mode, 0);
        chk("rst_out_kind", bus.out_kind, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        mon_en = 1'b1;

        // good frame, latency 1
        frame(8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00);
        chk("good_ov", bus.out_valid, 1);
        chk("good_mode", bus.out_mode, 2);
        chk("good_kind", bus.out_kind, 1);
        chk("good_data", bus.out_data, 32'h44332211);
        chk("good_err", bus.err_valid, 0);
        tick();

        // backpressure
        bus.out_ready = 1'b0;
        frame(8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00);
        for (int i = 0; i < 5; i++) begin
            chk("bp_ov", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_data", bus.out_data, 32'h44332211);
            chk("bp_mode", bus.out_mode, 2);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_ov", bus.out_valid, 0);
        chk("bp_release_in_ready", bus.in_ready, 1);
        frame(8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00);
        chk("bp_next_ov", bus.out_valid, 1);
        tick();

        // bad checksum
        frame(8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 8'h01);
        chk("csum_err_valid", bus.err_valid, 1);
        chk("csum_err_code", bus.err_code, 1);
        chk("csum_ov", bus.out_valid, 0);
        tick();
        chk("csum_pulse_len", bus.err_valid, 0);

        // illegal kind
        frame(8'h50, 8'h11, 8'h22, 8'h33, 8'h44, 8'h14);
        chk("kind_err_code", bus.err_code, 3);
        chk("kind_ov", bus.out_valid, 0);
        tick();

        // in_last on second payload byte
        push_err(2'd2);
        send(8'h44, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b1);
        chk("frm1_err_code", bus.err_code, 2);
        chk("frm1_ov", bus.out_valid, 0);
        frame(8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00);
        chk("frm1_recover_ov", bus.out_valid, 1);
        tick();

        // checksum without in_last, then drain
        push_err(2'd2);
        send(8'h44, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b0);
        send(8'h33, 1'b0); send(8'h44, 1'b0); send(8'h00, 1'b0);
        chk("frm2_err_code", bus.err_code, 2);
        send(8'hAA, 1'b0);
        chk("frm2_drain_ov", bus.out_valid, 0);
        send(8'hBB, 1'b1);
        chk("frm2_drain_ov2", bus.out_valid, 0);
        frame(8'h8C, 8'hA5, 8'h5A, 8'h0F, 8'hF0, 8'h8C);
        chk("frm2_recover_ov", bus.out_valid, 1);
        chk("frm2_recover_kind", bus.out_kind, 3);
        tick();

        // reset mid-frame
        send(8'h44, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", bus.in_ready, 0);
        tick();
        chk("midrst_ov", bus.out_valid, 0);
        chk("midrst_err", bus.err_valid, 0);
        rst = 1'b0;
        #1;
        frame(8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00);
        chk("midrst_good_ov", bus.out_valid, 1);
        chk("midrst_good_data", bus.out_data, 32'h44332211);
        tick();

        // random frames, some with corrupted checksum
        for (int i = 0; i < 12; i++) begin
            h = 8'($urandom); p0 = 8'($urandom); p1 = 8'($urandom);
            p2 = 8'($urandom); p3 = 8'($urandom);
            cs = h ^ p0 ^ p1 ^ p2 ^ p3;
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'h5A;
            frame(h, p0, p1, p2, p3, cs);
            tick();
        end

        repeat (3) tick();
        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cfg_record_unpacker.md
CFG_RECORD_UNPACKER -- requirements
Module: cfg_record_unpacker

Interface
REQ-001 SHALL have parameter PAYLOAD_BYTES, default 4, giving the payload bytes per frame; legal range 1..16.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, byte-stream valid.
REQ-005 SHALL have port in_data, input, 8, stream byte.
REQ-006 SHALL have port in_last, input, 1, final byte of frame (the checksum byte).
REQ-007 SHALL have port in_ready, output, 1, byte accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port out_valid, output, 1, decoded record valid.
REQ-009 SHALL have port out_ready, input, 1, record consumed when out_valid and out_ready are both high.
REQ-010 SHALL have port out_mode, output, 3, record mode field.
REQ-011 SHALL have port out_kind, output, 2, record kind: 0 STATE_0, 1 STATE_F0, 2 STATE_244, 3 STATE_DEFAULT.
REQ-012 SHALL have port out_data, output, 8*PAYLOAD_BYTES, payload, little-endian (first payload byte in bits [7:0]).
REQ-013 SHALL have port err_valid, output, 1, one-cycle error pulse.
REQ-014 SHALL have port err_code, output, 2, error cause: 1 checksum, 2 framing, 3 illegal kind; 0 when no error.

Function
REQ-015 SHALL use frame format: header byte, then PAYLOAD_BYTES payload bytes, then one checksum byte carrying in_last.
- Header fields: mode = bits [7:5], kind = bits [4:2]; bits [1:0] ignored.
REQ-016 SHALL implement states IDLE, PAYLOAD, CHECK, OUT and DRAIN.
- IDLE: accepts the header, goes to PAYLOAD.
- PAYLOAD: after accepting PAYLOAD_BYTES bytes, goes to CHECK.
- CHECK: accepts the checksum byte, then goes to OUT, or to IDLE on error.
- OUT: holds the record until handshake, then goes to IDLE.
- DRAIN: discards bytes up to and including an in_last byte, then goes to IDLE.
REQ-017 SHALL drive in_ready high in IDLE, PAYLOAD, CHECK and DRAIN, and low in OUT.
REQ-018 SHALL count payload bytes with a counter of width clog2(PAYLOAD_BYTES+1), cleared on every header acceptance.
REQ-019 SHALL compute the checksum as the XOR of the header and all payload bytes; the frame is good when this equals the checksum byte.
REQ-020 SHALL assert out_valid in the cycle after the checksum byte is accepted (latency 1 from that byte).
REQ-021 SHALL hold out_valid, out_mode, out_kind and out_data stable until out_ready is sampled high.
REQ-022 SHALL, on in_last with the header or any payload byte, pulse err_valid with err_code=2, drop the frame, and go to IDLE the next cycle.
REQ-023 SHALL, on a checksum byte without in_last, pulse err_code=2 and go to DRAIN.
REQ-024 SHALL, on checksum mismatch with correct framing, pulse err_code=1 and drop the record.
REQ-025 SHALL, on a good checksum with header kind greater than 3, pulse err_code=3 and drop the record.
REQ-026 SHALL resolve multiple errors on one frame with priority framing > checksum > kind; only one err_valid pulse is issued per frame.
REQ-027 SHALL issue err_valid in the cycle after the offending byte is accepted; err_code SHALL be 0 whenever err_valid is low.
REQ-028 SHALL ignore in_data, in_last and all other inputs in cycles without a handshake; no state changes on them.
REQ-029 SHALL, when out_ready is already high on the first cycle of out_valid, complete the handshake in that cycle, return to IDLE, and accept a new header the following cycle.

Reset
REQ-030 SHALL, on rst high at a clock edge, go to IDLE and clear the counter and checksum accumulator.
REQ-031 SHALL, during reset, drive out_valid=0, err_valid=0, err_code=0, out_mode=0, out_kind=0, out_data=0 and in_ready=0.
REQ-032 SHALL drive in_ready=1 in the first cycle after rst deasserts.
REQ-033 SHALL, when reset is asserted mid-frame or in OUT, discard the partial or pending record with no err_valid pulse.

Verification (PAYLOAD_BYTES=4)
REQ-034 SHALL cover a good frame: bytes 0x44,0x11,0x22,0x33,0x44,0x00 (in_last on the last), out_ready=1 -> one cycle later out_valid=1, out_mode=2, out_kind=1, out_data=0x44332211, err_valid=0.
REQ-035 SHALL cover backpressure: the same frame with out_ready=0 for 5 cycles -> in_ready=0 and outputs stable for 5 cycles; the record is released on out_ready=1; a next header is accepted the following cycle.
REQ-036 SHALL cover a bad checksum: the same frame with checksum byte 0x01 -> err_valid pulses one cycle with err_code=1, and out_valid stays 0.
REQ-037 SHALL cover an illegal kind: bytes 0x50,0x11,0x22,0x33,0x44,0x14 -> err_code=3, no record.
REQ-038 SHALL cover framing errors:
- in_last on the 2nd payload byte -> err_code=2, then IDLE.
- Checksum byte with in_last=0, followed by 0xAA and then 0xBB with in_last=1 -> one err_code=2 pulse, both bytes drained, then IDLE.
REQ-039 SHALL cover reset mid-frame: rst asserted after 3 payload bytes, then a good frame sent -> the good frame is decoded correctly with no error pulse.
